cpu_axi_arbiter: RTL and testbench
==================================

// Module: cpu_axi_arbiter
// PURPOSE: Shares one AXI master port between the core's SRAM-like instruction and data interfaces. Sits between mips and the SoC AXI crossbar.
//   Serialises requests, one transaction outstanding. Drives inst_stall/data_stall and holds returned read data until the pipeline advances.
//   AXI constants (ids, len=0, burst=INCR, wlast=1, lock/cache/prot) are tied off in the SoC wrapper.
// PARAMETERS:
//   DATA_FIRST  1  when inst and data requests are pending together in IDLE: 1 = data granted first, 0 = inst granted first
// PORTS:
//   clk            in   1   core clock; all logic on posedge
//   rst            in   1   asynchronous reset, active-low (rst==0 resets)
//   inst_en        in   1   instruction fetch request
//   inst_addr      in   32  fetch address (word aligned)
//   inst_rdata     out  32  fetched word; registered, held until next inst completion
//   inst_stall     out  1   fetch not yet complete
//   data_en        in   1   data access request
//   data_addr      in   32  data byte address
//   data_wen       in   4   byte write enables; 0 = read
//   data_wdata     in   32  store data, lane-aligned
//   data_rdata     out  32  load word; registered, held until next data completion
//   data_stall     out  1   data access not yet complete
//   longest_stall  in   1   core-wide stall; low = pipeline advances this cycle
//   araddr         out  32  AXI read address
//   arsize         out  3   AXI read size
//   arvalid        out  1   AXI read address valid
//   arready        in   1   AXI read address ready
//   rdata          in   32  AXI read data
//   rvalid         in   1   AXI read data valid
//   rready         out  1   AXI read data ready
//   awaddr         out  32  AXI write address
//   awsize         out  3   AXI write size
//   awvalid        out  1   AXI write address valid
//   awready        in   1   AXI write address ready
//   wdata          out  32  AXI write data
//   wstrb          out  4   AXI write strobes
//   wvalid         out  1   AXI write data valid
//   wready         in   1   AXI write data ready
//   bvalid         in   1   AXI write response valid
//   bready         out  1   AXI write response ready
// BEHAVIOUR:
// - Reset (rst=0, async): state=IDLE.
//   All AXI valid/ready outputs 0. inst_done=data_done=0. inst_rdata=data_rdata=0.
//   All address/size/strobe/data registers 0.
// - Pending requests: inst_req = inst_en & ~inst_done, data_req = data_en & ~data_done.
//   Stalls: inst_stall = inst_req, data_stall = data_req (combinational from registered done flags).
// - FSM states: IDLE, RD_A, RD_D, WR, WR_B.
//   - IDLE: grant one pending request according to DATA_FIRST, and capture its addr/wen/wdata into registers.
//     An inst grant or a data grant with data_wen==0 goes to RD_A; a data grant with data_wen!=0 goes to WR.
//   - RD_A: arvalid=1 until arready, then RD_D.
//   - RD_D: rready=1. On rvalid, latch rdata into the granted requester's rdata register, set its done flag, return to IDLE.
//   - WR: awvalid and wvalid both assert on entry; each drops after its own handshake.
//     Go to WR_B once both have handshaked, including the case where both handshake in the same cycle.
//   - WR_B: bready=1. On bvalid, set data_done and return to IDLE. bresp is ignored.
// - Read address and size: araddr = {addr[31:2],2'b00}, arsize = 3'd2.
// - Write address, size and data: wstrb = wen, wdata = captured wdata, awaddr = {addr[31:2], off}. off and awsize per wen:
//   - 1111: awsize=2, off=00.
//   - 0011 / 1100: awsize=1, off=00 / 10.
//   - 0001 / 0010 / 0100 / 1000: awsize=0, off=00 / 01 / 10 / 11.
//   - Any other pattern: awsize=2, off=00.
// - Done flags: both clear on the clock edge where longest_stall==0. A set in the same edge wins; this cannot occur legally.
//   A done flag is set only if that requester's en is high at completion; otherwise the result is discarded.
//   An AXI transaction, once granted, is never aborted.
// - Minimum read latency with arready=1 and rvalid one cycle after the AR handshake:
//   cycle 0 grant; cycle 1 AR handshake; cycle 2 R handshake; cycle 3 stall low with rdata valid.
// - A done requester issues no new transaction until longest_stall drops, so there is no duplicate fetch while the other side is still stalled.
// TESTING:
// - Inst fetch 0xBFC00000, AXI returns 0x24020001: araddr=0xBFC00000, arsize=2; inst_stall high cycles 0-2, low cycle 3; inst_rdata=0x24020001.
// - inst_en and data_en together, data read at 0x80000010, DATA_FIRST=1: data AR issued first, inst AR follows.
//   Both stalls stay high until each completes; one longest_stall=0 cycle clears both done flags.
// - Store wen=0100, addr 0x80000003, wdata 0x00AB0000, awready 2 cycles before wready:
//   exactly one AW handshake and one W handshake; awaddr=0x80000002, awsize=0, wstrb=0100; data_stall falls after bvalid.
// - Store wen=1100: awaddr low bits=10, awsize=1. Store wen=1111: awaddr low bits=00, awsize=2. AW and W handshaking in the same cycle goes directly to WR_B.
// - Inst completes while data load waits 5 cycles on rvalid: no second inst AR, inst_rdata stable. After longest_stall=0, the next fetch issues a new AR.
// - rst driven low during RD_D: arvalid/rready/stalls go to 0 immediately without waiting for clk. After rst=1 the FSM is in IDLE and a new request is granted normally.

Source files
------------

// File: rtl/cpu_axi_arbiter_if.sv
// Core-side SRAM-like fetch/data ports plus the single AXI master port of the arbiter.
// The master modport is the arbiter's view; slave is the core/crossbar side.
`timescale 1ns/1ps
interface cpu_axi_arbiter_if;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_en;
  logic [31:0] data_addr;
  logic [3:0]  data_wen;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        longest_stall;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_en, inst_addr, data_en, data_addr, data_wen, data_wdata, longest_stall,
    input  arready, rdata, rvalid, awready, wready, bvalid,
    output inst_rdata, inst_stall, data_rdata, data_stall,
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output inst_en, inst_addr, data_en, data_addr, data_wen, data_wdata, longest_stall,
    output arready, rdata, rvalid, awready, wready, bvalid,
    input  inst_rdata, inst_stall, data_rdata, data_stall,
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/cpu_axi_arbiter.sv
// Serialises core fetch and data requests onto one AXI port, one transaction outstanding;
// read latency 3 cycles minimum, stalls held until completion, results held until longest_stall drops.
`timescale 1ns/1ps
module cpu_axi_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  cpu_axi_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B} state_t;

  state_t      state_q;
  logic        gnt_data_q;
  logic        inst_done_q, data_done_q;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [2:0]  arsize_q, awsize_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  logic        inst_req, data_req, pick_data;
  logic [2:0]  awsize_d;
  logic [1:0]  awoff_d;

  assign inst_req  = bus.inst_en & ~inst_done_q;
  assign data_req  = bus.data_en & ~data_done_q;
  assign pick_data = data_req & (DATA_FIRST | ~inst_req);

  // Narrow stores get the smallest AXI size covering the lanes; odd patterns fall back to a full word.
  always_comb begin
    awsize_d = 3'd2;
    awoff_d  = 2'b00;
    case (bus.data_wen)
      4'b0011: begin awsize_d = 3'd1; awoff_d = 2'b00; end
      4'b1100: begin awsize_d = 3'd1; awoff_d = 2'b10; end
      4'b0001: begin awsize_d = 3'd0; awoff_d = 2'b00; end
      4'b0010: begin awsize_d = 3'd0; awoff_d = 2'b01; end
      4'b0100: begin awsize_d = 3'd0; awoff_d = 2'b10; end
      4'b1000: begin awsize_d = 3'd0; awoff_d = 2'b11; end
      default: begin awsize_d = 3'd2; awoff_d = 2'b00; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_data_q   <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      arsize_q     <= '0;
      awsize_q     <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      // Completion below is assigned later, so a set on the same edge wins over this clear.
      if (!bus.longest_stall) begin
        inst_done_q <= 1'b0;
        data_done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pick_data) begin
            gnt_data_q <= 1'b1;
            if (|bus.data_wen) begin
              awaddr_q  <= (bus.data_addr & 32'hFFFF_FFFC) | {30'd0, awoff_d};
              awsize_q  <= awsize_d;
              wstrb_q   <= bus.data_wen;
              wdata_q   <= bus.data_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              araddr_q  <= bus.data_addr & 32'hFFFF_FFFC;
              arsize_q  <= 3'd2;
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end else if (inst_req) begin
            gnt_data_q <= 1'b0;
            araddr_q   <= bus.inst_addr & 32'hFFFF_FFFC;
            arsize_q   <= 3'd2;
            arvalid_q  <= 1'b1;
            state_q    <= RD_A;
          end
        end
        RD_A: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            state_q  <= IDLE;
            // A requester that withdrew its enable has its result dropped.
            if (gnt_data_q) begin
              if (bus.data_en) begin
                data_rdata_q <= bus.rdata;
                data_done_q  <= 1'b1;
              end
            end else if (bus.inst_en) begin
              inst_rdata_q <= bus.rdata;
              inst_done_q  <= 1'b1;
            end
          end
        end
        WR: begin
          if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
            if (bus.data_en) data_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst_stall = inst_req;
  assign bus.data_stall = data_req;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.araddr     = araddr_q;
  assign bus.arsize     = arsize_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.awaddr     = awaddr_q;
  assign bus.awsize     = awsize_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.wvalid     = wvalid_q;
  assign bus.bready     = bready_q;
endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed bench for cpu_axi_arbiter: hand-computed expectations for fetches, loads, stores,
// arbitration order, held results and asynchronous reset.
`timescale 1ns/1ps
module tb_cpu_axi_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int   ar0, aw0, w0;

  always #5 clk = ~clk;

  cpu_axi_arbiter_if bus ();
  cpu_axi_arbiter #(.DATA_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) ar_cnt <= ar_cnt + 1;
    if (bus.awvalid && bus.awready) aw_cnt <= aw_cnt + 1;
    if (bus.wvalid && bus.wready)   w_cnt  <= w_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_stall();
    bus.longest_stall = 1'b0;
    bus.inst_en = 1'b0;
    bus.data_en = 1'b0;
    tick();
    bus.longest_stall = 1'b1;
  endtask

  // Store where AW and W handshake together: WR must go straight to WR_B.
  task automatic store_same(input string tag, input logic [31:0] a, input logic [3:0] wen,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [2:0] exp_size);
    bus.data_en = 1'b1; bus.data_addr = a; bus.data_wen = wen; bus.data_wdata = wd;
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    chk({tag, "_awaddr"}, bus.awaddr, exp_addr);
    chk({tag, "_awsize"}, {29'd0, bus.awsize}, {29'd0, exp_size});
    chk({tag, "_wstrb"}, {28'd0, bus.wstrb}, {28'd0, wen});
    chk({tag, "_wdata"}, bus.wdata, wd);
    chk({tag, "_both_vld"}, {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    tick();
    chk({tag, "_wrb_bready"}, {29'd0, bus.bready, bus.awvalid, bus.wvalid}, 32'd4);
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    chk({tag, "_stall_done"}, {31'd0, bus.data_stall}, 32'd0);
    release_stall();
  endtask

  initial begin
    bus.inst_en = 1'b0; bus.inst_addr = '0;
    bus.data_en = 1'b0; bus.data_addr = '0; bus.data_wen = '0; bus.data_wdata = '0;
    bus.longest_stall = 1'b1;
    bus.arready = 1'b0; bus.rdata = '0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
    chk("rst_inst_rdata", bus.inst_rdata, 32'd0);
    chk("rst_data_rdata", bus.data_rdata, 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_awaddr", bus.awaddr, 32'd0);
    rst = 1'b1;
    tick();

    // Single fetch, minimum latency
    ar0 = ar_cnt;
    bus.inst_en = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.arready = 1'b1;
    #1 chk("f1_stall_c0", {31'd0, bus.inst_stall}, 32'd1);
    tick();
    chk("f1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("f1_araddr", bus.araddr, 32'hBFC0_0000);
    chk("f1_arsize", {29'd0, bus.arsize}, 32'd2);
    chk("f1_stall_c1", {31'd0, bus.inst_stall}, 32'd1);
    tick();
    chk("f1_rready", {31'd0, bus.rready}, 32'd1);
    chk("f1_stall_c2", {31'd0, bus.inst_stall}, 32'd1);
    bus.rvalid = 1'b1; bus.rdata = 32'h2402_0001;
    tick();
    bus.rvalid = 1'b0;
    chk("f1_stall_c3", {31'd0, bus.inst_stall}, 32'd0);
    chk("f1_rdata", bus.inst_rdata, 32'h2402_0001);
    chk("f1_ar_count", ar_cnt - ar0, 32'd1);
    release_stall();

    // Simultaneous fetch and load: data first
    ar0 = ar_cnt;
    bus.inst_en = 1'b1; bus.inst_addr = 32'hBFC0_0004;
    bus.data_en = 1'b1; bus.data_addr = 32'h8000_0010; bus.data_wen = 4'b0000;
    tick();
    chk("both_first_araddr", bus.araddr, 32'h8000_0010);
    chk("both_stalls_c1", {30'd0, bus.inst_stall, bus.data_stall}, 32'd3);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hDDDD_0001;
    tick();
    bus.rvalid = 1'b0;
    chk("both_data_done", {30'd0, bus.inst_stall, bus.data_stall}, 32'd2);
    chk("both_data_rdata", bus.data_rdata, 32'hDDDD_0001);
    tick();
    chk("both_second_araddr", bus.araddr, 32'hBFC0_0004);
    chk("both_second_arvalid", {31'd0, bus.arvalid}, 32'd1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_0002;
    tick();
    bus.rvalid = 1'b0;
    chk("both_all_done", {30'd0, bus.inst_stall, bus.data_stall}, 32'd0);
    chk("both_inst_rdata", bus.inst_rdata, 32'h1111_0002);
    chk("both_ar_count", ar_cnt - ar0, 32'd2);
    bus.longest_stall = 1'b0;
    tick();
    bus.longest_stall = 1'b1;
    chk("both_done_cleared", {30'd0, bus.inst_stall, bus.data_stall}, 32'd3);
    bus.inst_en = 1'b0; bus.data_en = 1'b0;
    tick();

    // Byte store, awready two cycles ahead of wready
    aw0 = aw_cnt; w0 = w_cnt;
    bus.data_en = 1'b1; bus.data_addr = 32'h8000_0003; bus.data_wen = 4'b0100;
    bus.data_wdata = 32'h00AB_0000; bus.awready = 1'b1; bus.wready = 1'b0;
    tick();
    chk("sb_awaddr", bus.awaddr, 32'h8000_0002);
    chk("sb_awsize", {29'd0, bus.awsize}, 32'd0);
    chk("sb_wstrb", {28'd0, bus.wstrb}, 32'h4);
    chk("sb_wdata", bus.wdata, 32'h00AB_0000);
    chk("sb_both_vld", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    tick();
    chk("sb_aw_dropped", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
    tick();
    bus.wready = 1'b1;
    tick();
    chk("sb_in_wrb", {29'd0, bus.bready, bus.awvalid, bus.wvalid}, 32'd4);
    chk("sb_stall_before_b", {31'd0, bus.data_stall}, 32'd1);
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    chk("sb_stall_after_b", {31'd0, bus.data_stall}, 32'd0);
    chk("sb_aw_count", aw_cnt - aw0, 32'd1);
    chk("sb_w_count", w_cnt - w0, 32'd1);
    release_stall();

    store_same("sh", 32'h8000_0020, 4'b1100, 32'hBEEF_0000, 32'h8000_0022, 3'd1);
    store_same("sw", 32'h8000_0033, 4'b1111, 32'h1234_5678, 32'h8000_0030, 3'd2);
    store_same("sodd", 32'h8000_0045, 4'b0110, 32'h0055_6600, 32'h8000_0044, 3'd2);
    bus.awready = 1'b0; bus.wready = 1'b0;

    // Fetch completes, then a slow load: no refetch while data is stalled
    ar0 = ar_cnt;
    bus.inst_en = 1'b1; bus.inst_addr = 32'hBFC0_0008;
    tick();
    bus.data_en = 1'b1; bus.data_addr = 32'h8000_0040; bus.data_wen = 4'b0000;
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hAAAA_0003;
    tick();
    bus.rvalid = 1'b0;
    chk("slow_inst_done", {31'd0, bus.inst_stall}, 32'd0);
    tick();
    chk("slow_load_araddr", bus.araddr, 32'h8000_0040);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("slow_wait_rdata", bus.inst_rdata, 32'hAAAA_0003);
      chk("slow_wait_no_ar", {30'd0, bus.arvalid, bus.inst_stall}, 32'd0);
      chk("slow_wait_dstall", {31'd0, bus.data_stall}, 32'd1);
      tick();
    end
    bus.rvalid = 1'b1; bus.rdata = 32'hBBBB_0004;
    tick();
    bus.rvalid = 1'b0;
    chk("slow_load_done", {31'd0, bus.data_stall}, 32'd0);
    chk("slow_load_rdata", bus.data_rdata, 32'hBBBB_0004);
    chk("slow_ar_count", ar_cnt - ar0, 32'd2);
    bus.longest_stall = 1'b0; bus.data_en = 1'b0; bus.inst_addr = 32'hBFC0_000C;
    tick();
    bus.longest_stall = 1'b1;
    chk("next_fetch_stall", {31'd0, bus.inst_stall}, 32'd1);
    tick();
    chk("next_fetch_araddr", bus.araddr, 32'hBFC0_000C);
    chk("next_fetch_arvalid", {31'd0, bus.arvalid}, 32'd1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h3C1D_0000;
    tick();
    bus.rvalid = 1'b0;
    chk("next_fetch_rdata", bus.inst_rdata, 32'h3C1D_0000);
    release_stall();

    // Asynchronous reset in the middle of a read data phase
    bus.data_en = 1'b1; bus.data_addr = 32'h8000_0050; bus.data_wen = 4'b0000;
    tick();
    tick();
    chk("arst_in_rdd", {31'd0, bus.rready}, 32'd1);
    #2;
    rst = 1'b0; bus.data_en = 1'b0;
    #1;
    chk("arst_valids", {30'd0, bus.arvalid, bus.rready}, 32'd0);
    chk("arst_stalls", {30'd0, bus.inst_stall, bus.data_stall}, 32'd0);
    chk("arst_data_rdata", bus.data_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.data_en = 1'b1; bus.data_addr = 32'h8000_0060;
    tick();
    chk("post_rst_araddr", bus.araddr, 32'h8000_0060);
    chk("post_rst_arvalid", {31'd0, bus.arvalid}, 32'd1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA;
    tick();
    bus.rvalid = 1'b0;
    chk("post_rst_rdata", bus.data_rdata, 32'h5555_AAAA);
    chk("post_rst_stall", {31'd0, bus.data_stall}, 32'd0);
    release_stall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
